// File: rtl/efb_wb_arbiter_pkg.sv
// Shared Wishbone widths, arbiter state encoding and helpers
// for the EFB/UFM bus arbiter.
package efb_wb_arbiter_pkg;

  localparam int WB_ADR_W = 8;
  localparam int WB_DAT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  // One-hot (up to 4 bits) to binary; all-zero maps to 0.
  function automatic logic [1:0] oh2bin(input logic [3:0] oh);
    logic [1:0] b;
    b[0] = oh[1] | oh[3];
    b[1] = oh[2] | oh[3];
    return b;
  endfunction

endpackage

// File: rtl/efb_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or
// after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/efb_wb_arbiter.sv
// Round-robin arbiter sharing the EFB/UFM Wishbone slave port
// between several masters, with a no-ack watchdog.
module efb_wb_arbiter
  import efb_wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 255,
  parameter int TO_W        = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [WB_ADR_W*NUM_MASTERS-1:0] m_adr_i,
  input  logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_i,
  output logic [WB_DAT_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [WB_ADR_W-1:0]             s_adr_o,
  output logic [WB_DAT_W-1:0]             s_dat_o,
  input  logic [WB_DAT_W-1:0]             s_dat_i,
  input  logic                            s_ack_i,
  output logic [NUM_MASTERS-1:0]          gnt_o,
  output logic                            busy_o
);

  localparam int N  = NUM_MASTERS;
  localparam int IW = $clog2(N);
  localparam logic [TO_W-1:0] WD_LAST =
    TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e    state, state_n;
  logic [N-1:0]  gnt, gnt_n;
  logic [N-1:0]  blocked, blocked_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [TO_W-1:0] wd, wd_n;

  logic [N-1:0]  req, pick_gnt;
  logic [IW-1:0] pick_idx, own;
  logic          any;
  logic          own_cyc, own_stb;
  logic          stall, expire;

  assign req = m_cyc_i & ~blocked;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (any)
  );

  assign own     = IW'(oh2bin(4'(gnt)));
  assign own_cyc = m_cyc_i[own];
  assign own_stb = m_stb_i[own];

  // Stalled = owner strobing with no ack from the slave.
  assign stall  = (state == OWN) & own_cyc & own_stb & ~s_ack_i;
  assign expire = (TIMEOUT != 0) && stall && (wd == WD_LAST);

  assign m_dat_o = s_dat_i;
  assign gnt_o   = rst ? '0 : gnt;

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    ptr_n     = ptr;
    wd_n      = '0;
    blocked_n = blocked & m_cyc_i;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    busy_o    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_n = OWN;
          gnt_n   = pick_gnt;
          ptr_n   = (pick_idx == IW'(N - 1)) ? '0
                  : pick_idx + 1'b1;
        end
      end
      OWN: begin
        busy_o  = 1'b1;
        s_cyc_o = own_cyc;
        s_stb_o = own_stb;
        s_we_o  = m_we_i[own];
        s_adr_o = m_adr_i[WB_ADR_W*own +: WB_ADR_W];
        s_dat_o = m_dat_i[WB_DAT_W*own +: WB_DAT_W];
        m_ack_o = gnt & {N{s_ack_i}};
        if (stall && !expire) wd_n = wd + 1'b1;
        if (expire) begin
          s_cyc_o   = 1'b0;
          s_stb_o   = 1'b0;
          m_err_o   = gnt;
          blocked_n = blocked_n | gnt;
          state_n   = GAP;
          gnt_n     = '0;
        end else if (!own_cyc) begin
          state_n = GAP;
          gnt_n   = '0;
        end
      end
      GAP: state_n = IDLE;
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
    // Release the bus in the reset cycle itself.
    if (rst) begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      m_ack_o = '0;
      m_err_o = '0;
      busy_o  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      ptr     <= '0;
      wd      <= '0;
      blocked <= '0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      ptr     <= ptr_n;
      wd      <= wd_n;
      blocked <= blocked_n;
    end
  end

endmodule

// File: tb/tb_efb_wb_arbiter.sv
// Directed bench for efb_wb_arbiter: a cycle table plus
// hand sequences for reset, watchdog and blocking.
module tb_efb_wb_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] m_cyc, m_stb, m_we;
  logic [7:0] a0, a1, d0, d1;
  logic [7:0] m_dat_o;
  logic [1:0] m_ack_o, m_err_o;
  logic       s_cyc_o, s_stb_o, s_we_o;
  logic [7:0] s_adr_o, s_dat_o;
  logic [7:0] s_dat_i;
  logic       s_ack_i;
  logic [1:0] gnt_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;

  efb_wb_arbiter #(
    .NUM_MASTERS(2), .TIMEOUT(8), .TO_W(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_we_i  (m_we),
    .m_adr_i ({a1, a0}),
    .m_dat_i ({d1, d0}),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .gnt_o   (gnt_o),
    .busy_o  (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] cyc, stb, we;
    logic [7:0] a0, a1, d0;
    logic       ack;
    logic [7:0] sd;
    logic       e_cyc, e_stb, e_we;
    logic [7:0] e_adr, e_dat;
    logic [1:0] e_ack, e_gnt;
    logic       e_busy;
  } vec_t;

  vec_t tbl[27];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1,0,0,0,8'h00,8'h00,8'h00,0,8'h00,
                0,0,0,8'h00,8'h00,0,0,0};
    tbl[1]  = '{0,0,0,0,8'h00,8'h00,8'h00,0,8'h00,
                0,0,0,8'h00,8'h00,0,0,0};
    tbl[2]  = '{0,1,1,1,8'h70,8'h00,8'h5A,0,8'h00,
                0,0,0,8'h00,8'h00,0,0,0};
    tbl[3]  = '{0,1,1,1,8'h70,8'h00,8'h5A,0,8'h00,
                1,1,1,8'h70,8'h5A,0,1,1};
    tbl[4]  = '{0,1,1,1,8'h70,8'h00,8'h5A,0,8'h00,
                1,1,1,8'h70,8'h5A,0,1,1};
    tbl[5]  = '{0,1,1,1,8'h70,8'h00,8'h5A,1,8'h00,
                1,1,1,8'h70,8'h5A,1,1,1};
    tbl[6]  = '{0,0,0,0,8'h00,8'h00,8'h00,0,8'h00,
                0,0,0,8'h00,8'h00,0,1,1};
    tbl[7]  = '{0,0,0,0,8'h00,8'h00,8'h00,0,8'h00,
                0,0,0,8'h00,8'h00,0,0,0};
    tbl[8]  = '{0,0,0,0,8'h00,8'h00,8'h00,0,8'h00,
                0,0,0,8'h00,8'h00,0,0,0};
    tbl[9]  = '{1,0,0,0,8'h00,8'h00,8'h00,0,8'h00,
                0,0,0,8'h00,8'h00,0,0,0};
    tbl[10] = '{0,3,3,0,8'h10,8'h20,8'h00,0,8'h00,
                0,0,0,8'h00,8'h00,0,0,0};
    tbl[11] = '{0,3,3,0,8'h10,8'h20,8'h00,1,8'h00,
                1,1,0,8'h10,8'h00,1,1,1};
    tbl[12] = '{0,2,2,0,8'h00,8'h20,8'h00,0,8'h00,
                0,0,0,8'h00,8'h00,0,1,1};
    tbl[13] = '{0,3,3,0,8'h10,8'h20,8'h00,0,8'h00,
                0,0,0,8'h00,8'h00,0,0,0};
    tbl[14] = '{0,3,3,0,8'h10,8'h20,8'h00,0,8'h00,
                0,0,0,8'h00,8'h00,0,0,0};
    tbl[15] = '{0,3,3,0,8'h10,8'h20,8'h00,1,8'h00,
                1,1,0,8'h20,8'h00,2,2,1};
    tbl[16] = '{0,1,1,0,8'h10,8'h00,8'h00,0,8'h00,
                0,0,0,8'h00,8'h00,0,2,1};
    tbl[17] = '{0,3,3,0,8'h10,8'h20,8'h00,0,8'h00,
                0,0,0,8'h00,8'h00,0,0,0};
    tbl[18] = '{0,3,3,0,8'h10,8'h20,8'h00,0,8'h00,
                0,0,0,8'h00,8'h00,0,0,0};
    tbl[19] = '{0,3,3,0,8'h10,8'h20,8'h00,1,8'h00,
                1,1,0,8'h10,8'h00,1,1,1};
    tbl[20] = '{0,3,3,0,8'h10,8'h20,8'h00,1,8'h00,
                1,1,0,8'h10,8'h00,1,1,1};
    tbl[21] = '{0,3,3,0,8'h10,8'h20,8'h00,1,8'h00,
                1,1,0,8'h10,8'h00,1,1,1};
    tbl[22] = '{0,3,3,0,8'h72,8'h20,8'h00,1,8'hC3,
                1,1,0,8'h72,8'h00,1,1,1};
    tbl[23] = '{0,2,2,0,8'h00,8'h20,8'h00,0,8'h00,
                0,0,0,8'h00,8'h00,0,1,1};
    tbl[24] = '{0,2,2,0,8'h00,8'h20,8'h00,0,8'h00,
                0,0,0,8'h00,8'h00,0,0,0};
    tbl[25] = '{0,2,2,0,8'h00,8'h20,8'h00,0,8'h00,
                0,0,0,8'h00,8'h00,0,0,0};
    tbl[26] = '{0,2,2,0,8'h00,8'h20,8'h00,0,8'h00,
                1,1,0,8'h20,8'h00,0,2,1};

    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    s_dat_i = '0; s_ack_i = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 27; i++) begin
      next_cycle();
      rst = tbl[i].rst;
      m_cyc = tbl[i].cyc; m_stb = tbl[i].stb;
      m_we = tbl[i].we;
      a0 = tbl[i].a0; a1 = tbl[i].a1; d0 = tbl[i].d0;
      s_ack_i = tbl[i].ack; s_dat_i = tbl[i].sd;
      #1;
      chk($sformatf("r%0d_s_cyc", i), 32'(s_cyc_o),
          32'(tbl[i].e_cyc));
      chk($sformatf("r%0d_s_stb", i), 32'(s_stb_o),
          32'(tbl[i].e_stb));
      chk($sformatf("r%0d_s_we", i), 32'(s_we_o),
          32'(tbl[i].e_we));
      chk($sformatf("r%0d_s_adr", i), 32'(s_adr_o),
          32'(tbl[i].e_adr));
      chk($sformatf("r%0d_s_dat", i), 32'(s_dat_o),
          32'(tbl[i].e_dat));
      chk($sformatf("r%0d_m_ack", i), 32'(m_ack_o),
          32'(tbl[i].e_ack));
      chk($sformatf("r%0d_m_err", i), 32'(m_err_o), 0);
      chk($sformatf("r%0d_gnt", i), 32'(gnt_o),
          32'(tbl[i].e_gnt));
      chk($sformatf("r%0d_busy", i), 32'(busy_o),
          32'(tbl[i].e_busy));
      chk($sformatf("r%0d_m_dat", i), 32'(m_dat_o),
          32'(tbl[i].sd));
    end

    // Reset while m1 owns the bus with stb high
    next_cycle();
    rst = 1'b1; s_ack_i = 1'b1;
    #1;
    chk("rst_s_cyc", 32'(s_cyc_o), 0);
    chk("rst_s_stb", 32'(s_stb_o), 0);
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_m_ack", 32'(m_ack_o), 0);
    chk("rst_busy", 32'(busy_o), 0);

    next_cycle();
    rst = 1'b0; s_ack_i = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11;
    a0 = 8'h10; a1 = 8'h20;
    #1;
    chk("post_rst_idle_gnt", 32'(gnt_o), 0);
    next_cycle();
    #1;
    chk("post_rst_ptr0_gnt", 32'(gnt_o), 1);

    // Watchdog: m0 stalls, m1 waiting
    chk("wd_k1_err", 32'(m_err_o), 0);
    chk("wd_k1_s_cyc", 32'(s_cyc_o), 1);
    for (int k = 2; k <= 8; k++) begin
      next_cycle();
      #1;
      if (k < 8) begin
        chk($sformatf("wd_k%0d_err", k), 32'(m_err_o), 0);
        chk($sformatf("wd_k%0d_s_cyc", k), 32'(s_cyc_o), 1);
      end else begin
        chk("wd_exp_err", 32'(m_err_o), 1);
        chk("wd_exp_s_cyc", 32'(s_cyc_o), 0);
        chk("wd_exp_s_stb", 32'(s_stb_o), 0);
        chk("wd_exp_m_ack", 32'(m_ack_o), 0);
        chk("wd_exp_gnt", 32'(gnt_o), 1);
      end
    end
    next_cycle();
    #1;
    chk("wd_gap_s_cyc", 32'(s_cyc_o), 0);
    chk("wd_gap_err", 32'(m_err_o), 0);
    chk("wd_gap_gnt", 32'(gnt_o), 0);
    next_cycle();
    #1;
    chk("wd_idle_gnt", 32'(gnt_o), 0);
    next_cycle();
    #1;
    chk("wd_m1_gnt", 32'(gnt_o), 2);
    chk("wd_m1_adr", 32'(s_adr_o), 32'h20);

    next_cycle();
    m_cyc = 2'b01; m_stb = 2'b01;
    #1;
    chk("m1_rel_s_cyc", 32'(s_cyc_o), 0);
    chk("m1_rel_gnt", 32'(gnt_o), 2);
    next_cycle();
    #1;
    chk("m1_rel_gap_gnt", 32'(gnt_o), 0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      #1;
      chk($sformatf("blocked_%0d_gnt", k), 32'(gnt_o), 0);
      chk($sformatf("blocked_%0d_busy", k), 32'(busy_o), 0);
    end
    next_cycle();
    m_cyc = 2'b00; m_stb = 2'b00;
    #1;
    chk("unblk_low_gnt", 32'(gnt_o), 0);
    next_cycle();
    m_cyc = 2'b01; m_stb = 2'b01;
    #1;
    chk("unblk_idle_gnt", 32'(gnt_o), 0);
    next_cycle();
    #1;
    chk("unblk_gnt", 32'(gnt_o), 1);

    // Ack on what would be the expiry cycle wins
    for (int k = 2; k <= 8; k++) begin
      next_cycle();
      if (k == 8) s_ack_i = 1'b1;
      #1;
    end
    chk("ackwin_m_ack", 32'(m_ack_o), 1);
    chk("ackwin_m_err", 32'(m_err_o), 0);
    chk("ackwin_s_cyc", 32'(s_cyc_o), 1);
    next_cycle();
    s_ack_i = 1'b0;
    #1;
    chk("ackwin_after_busy", 32'(busy_o), 1);
    chk("ackwin_after_gnt", 32'(gnt_o), 1);
    chk("ackwin_after_err", 32'(m_err_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
